// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
//   state_t      : FSM state encoding (IDLE, SHIFT, HOLD)
//   count_width  : width of the bit counter for a given word length,
//                  wide enough to hold the value WIDTH itself
package sipo_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Counter must reach WIDTH (not just WIDTH-1), hence the extra bit.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sipo_deserializer_shift_core.sv
// WIDTH-bit shift register used by sipo_deserializer.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   clear      : discard current contents (new frame)
//   shift_en   : insert 'in' this cycle
//   in         : serial data bit
//   word       : registered shift register contents
//   next_word  : value the register takes at the next edge; lets the
//                owner capture a complete word on the same edge as the
//                final bit
module sipo_deserializer_shift_core
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             in,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] next_word
);

  logic [WIDTH-1:0] base;

  // Next-state of the shift register. With clear and shift_en together
  // the new bit lands on an all-zero register (start + first bit).
  always_comb begin
    base      = {WIDTH{1'b0}};
    next_word = {WIDTH{1'b0}};
    if (clear) begin
      base = {WIDTH{1'b0}};
    end else begin
      base = word;
    end
    if (shift_en) begin
      if (MSB_FIRST) begin
        // First bit travels up to word[WIDTH-1].
        next_word = {base[WIDTH-2:0], in};
      end else begin
        // First bit travels down to word[0].
        next_word = {in, base[WIDTH-1:1]};
      end
    end else begin
      next_word = base;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= {WIDTH{1'b0}};
    end else begin
      word <= next_word;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver with framing, bit counter,
// valid/ready output holding and sticky overrun detection.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : begin a new frame (aborts any partial frame)
//   in         : serial data bit, qualified by in_valid
//   in_valid   : 'in' is meaningful this cycle
//   out_word   : assembled word, only updated when a word completes
//   out_valid  : out_word holds an unconsumed word
//   out_ready  : consumer takes the word on out_valid & out_ready
//   busy       : frame in progress (SHIFT state)
//   bit_count  : bits captured in the current frame (WIDTH while held)
//   overrun    : sticky; data or start arrived while a word was held
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in,
  input  logic                              in_valid,
  output logic [WIDTH-1:0]                  out_word,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [count_width(WIDTH)-1:0]     bit_count,
  output logic                              overrun
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  state_t           state;
  logic             sr_clear;
  logic             sr_shift;
  logic             handshake;
  logic [WIDTH-1:0] sr_word;
  logic [WIDTH-1:0] sr_next;

  sipo_deserializer_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (sr_clear),
    .shift_en  (sr_shift),
    .in        (in),
    .word      (sr_word),
    .next_word (sr_next)
  );

  // Shift register controls. In HOLD the register is frozen unless the
  // handshake edge also starts a new frame.
  always_comb begin
    sr_clear  = 1'b0;
    sr_shift  = 1'b0;
    handshake = out_valid & out_ready;
    case (state)
      ST_IDLE: begin
        if (start) begin
          sr_clear = 1'b1;
          sr_shift = in_valid;
        end else begin
          sr_shift = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          sr_clear = 1'b1;
          sr_shift = in_valid;
        end else begin
          sr_shift = in_valid;
        end
      end
      ST_HOLD: begin
        if (handshake && start) begin
          sr_clear = 1'b1;
          sr_shift = in_valid;
        end else begin
          sr_shift = 1'b0;
        end
      end
      default: begin
        sr_clear = 1'b1;
        sr_shift = 1'b0;
      end
    endcase
  end

  // Frame FSM with registered outputs. Priority: rst > handshake >
  // start > in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_word  <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
      busy      <= 1'b0;
      bit_count <= CNT_ZERO;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SHIFT;
            busy      <= 1'b1;
            bit_count <= in_valid ? CNT_ONE : CNT_ZERO;
          end
        end
        ST_SHIFT: begin
          if (start) begin
            bit_count <= in_valid ? CNT_ONE : CNT_ZERO;
          end else if (in_valid) begin
            if (bit_count == CNT_LAST) begin
              // sr_next already contains the final bit.
              out_word  <= sr_next;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
              busy      <= 1'b0;
              bit_count <= CNT_FULL;
            end else begin
              bit_count <= bit_count + CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (start) begin
              state     <= ST_SHIFT;
              busy      <= 1'b1;
              bit_count <= in_valid ? CNT_ONE : CNT_ZERO;
            end else begin
              state     <= ST_IDLE;
              bit_count <= CNT_ZERO;
            end
          end else if (start || in_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          bit_count <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (WIDTH=8).
// Instance dut uses LSB-first assembly, dut_m uses MSB-first; both see
// the same input stream.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] out_word;
  logic       out_valid;
  logic       busy;
  logic [3:0] bit_count;
  logic       overrun;
  logic [7:0] m_out_word;
  logic       m_out_valid;
  logic       m_busy;
  logic [3:0] m_bit_count;
  logic       m_overrun;

  int total;
  int bad;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .in_valid(in_valid),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .bit_count(bit_count), .overrun(overrun)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .in(in), .in_valid(in_valid),
    .out_word(m_out_word), .out_valid(m_out_valid), .out_ready(out_ready),
    .busy(m_busy), .bit_count(m_bit_count), .overrun(m_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs are already driven, sample 1 time unit after edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic b);
    start    = s;
    in_valid = 1'b1;
    in       = b;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    in       = 1'b0;
  endtask

  task automatic idle_cycle();
    start    = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  // Sends w[0] first, start asserted with the first bit.
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      send_bit(i == 0, w[i]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_word",  out_word, 32'h0);
    chk("rst_valid", out_valid, 32'h0);
    chk("rst_busy",  busy, 32'h0);
    chk("rst_cnt",   bit_count, 32'h0);
    chk("rst_ovr",   overrun, 32'h0);

    // Test 1: LSB-first 0x96, consumer always ready
    out_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("t1_busy", busy, 32'h1);
    chk("t1_cnt1", bit_count, 32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t1_novalid7", out_valid, 32'h0);
    send_bit(1'b0, 1'b1);
    chk("t1_valid",  out_valid, 32'h1);
    chk("t1_word",   out_word, 32'h96);
    chk("t1_cnt8",   bit_count, 32'h8);
    chk("t1_busy0",  busy, 32'h0);
    chk("t1_mword",  m_out_word, 32'h69);
    idle_cycle();
    chk("t1_pulse",  out_valid, 32'h0);
    chk("t1_idlecnt", bit_count, 32'h0);
    chk("t1_idlebusy", busy, 32'h0);
    chk("t1_keep",   out_word, 32'h96);
    idle_cycle();
    chk("t1_stray",  bit_count, 32'h0);

    // Test 2: gaps in the stream and a stalled consumer
    out_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    idle_cycle();
    chk("t2_gapcnt", bit_count, 32'h3);
    chk("t2_gapbusy", busy, 32'h1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    idle_cycle();
    chk("t2_gapcnt2", bit_count, 32'h6);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("t2_valid", out_valid, 32'h1);
    chk("t2_word",  out_word, 32'h96);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      chk("t2_hold_valid", out_valid, 32'h1);
      chk("t2_hold_word",  out_word, 32'h96);
      chk("t2_hold_cnt",   bit_count, 32'h8);
    end
    out_ready = 1'b1;
    idle_cycle();
    chk("t2_taken", out_valid, 32'h0);
    chk("t2_cnt0",  bit_count, 32'h0);
    chk("t2_ovr",   overrun, 32'h0);

    // Test 3: stream 1,0,0,1,0,1,1,0 -> 0x96 MSB-first, 0x69 LSB-first
    send_word(8'h69);
    chk("t3_mvalid", m_out_valid, 32'h1);
    chk("t3_mword",  m_out_word, 32'h96);
    chk("t3_word",   out_word, 32'h69);
    idle_cycle();

    // Test 4: abort after 5 ones, restart with 8 zeros
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    chk("t4_cnt5", bit_count, 32'h5);
    send_bit(1'b1, 1'b0);
    chk("t4_restart_cnt", bit_count, 32'h1);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b0, 1'b0);
      chk("t4_novalid", out_valid, 32'h0);
    end
    send_bit(1'b0, 1'b0);
    chk("t4_valid", out_valid, 32'h1);
    chk("t4_word",  out_word, 32'h00);
    idle_cycle();

    // Test 5: overrun while word held
    out_ready = 1'b0;
    send_word(8'h3C);
    chk("t5_valid", out_valid, 32'h1);
    chk("t5_ovr0",  overrun, 32'h0);
    send_bit(1'b0, 1'b1);
    chk("t5_ovr1",  overrun, 32'h1);
    chk("t5_word",  out_word, 32'h3C);
    chk("t5_cnt",   bit_count, 32'h8);
    chk("t5_mword", m_out_word, 32'h3C);
    out_ready = 1'b1;
    idle_cycle();
    chk("t5_taken",  out_valid, 32'h0);
    chk("t5_sticky", overrun, 32'h1);
    // start alone in HOLD also flags overrun (fresh after reset below)

    // Test 6: reset mid-frame, clean frame, back-to-back frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_word",  out_word, 32'h0);
    chk("t6_rst_valid", out_valid, 32'h0);
    chk("t6_rst_busy",  busy, 32'h0);
    chk("t6_rst_cnt",   bit_count, 32'h0);
    chk("t6_rst_ovr",   overrun, 32'h0);
    send_word(8'hA5);
    chk("t6_valid", out_valid, 32'h1);
    chk("t6_word",  out_word, 32'hA5);
    // Handshake edge carries start + first bit of next word (0x5A).
    send_bit(1'b1, 1'b0);
    chk("t6_b2b_valid", out_valid, 32'h0);
    chk("t6_b2b_busy",  busy, 32'h1);
    chk("t6_b2b_cnt",   bit_count, 32'h1);
    for (int i = 1; i < 8; i++) send_bit(1'b0, ((8'h5A >> i) & 8'h01) != 8'h00);
    chk("t6_valid2", out_valid, 32'h1);
    chk("t6_word2",  out_word, 32'h5A);
    chk("t6_ovr",    overrun, 32'h0);

    // Start without handshake in HOLD sets overrun, word unchanged
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t7_ovr",   overrun, 32'h1);
    chk("t7_valid", out_valid, 32'h1);
    chk("t7_word",  out_word, 32'h5A);
    chk("t7_busy",  busy, 32'h0);
    out_ready = 1'b1;
    idle_cycle();
    chk("t7_idle",  out_valid, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
